// File: rtl/ysyx_25020037_gpr_scoreboard_if.sv
// Issue/retire/status bundle between the IDU/WBU side and the GPR scoreboard.
// Issue: idu_valid/issue_ready handshake with rs1/rs2/rd decode fields and csr_op.
// Retire: wbu_valid with wb_rd/wb_wen/wb_csr; flush squash; status: inflight, pend_any, err_underflow.
interface ysyx_25020037_gpr_scoreboard_if;
   logic       idu_valid;
   logic       issue_ready;
   logic [4:0] rs1;
   logic       rs1_used;
   logic [4:0] rs2;
   logic       rs2_used;
   logic [4:0] rd;
   logic       rd_wen;
   logic       csr_op;
   logic       wbu_valid;
   logic [4:0] wb_rd;
   logic       wb_wen;
   logic       wb_csr;
   logic       flush;
   logic [2:0] inflight;
   logic       pend_any;
   logic       err_underflow;

   // pipeline side (drives decode/retire, observes readiness and status)
   modport master (
      output idu_valid, rs1, rs1_used, rs2, rs2_used, rd, rd_wen, csr_op,
      output wbu_valid, wb_rd, wb_wen, wb_csr, flush,
      input  issue_ready, inflight, pend_any, err_underflow
   );

   // scoreboard side
   modport slave (
      input  idu_valid, rs1, rs1_used, rs2, rs2_used, rd, rd_wen, csr_op,
      input  wbu_valid, wb_rd, wb_wen, wb_csr, flush,
      output issue_ready, inflight, pend_any, err_underflow
   );
endinterface

// File: rtl/ysyx_25020037_gpr_scoreboard.sv
// RV32E GPR/CSR issue scoreboard: tracks in-flight writes between IDU issue and WBU retire.
// Latency: issue_ready is combinational from registered state + current issue inputs; retire frees a
// dependant one cycle later (no bypass). Backpressure: issue_ready drops on RAW, counter saturation,
// CSR busy, DEPTH in-flight limit, flush, or reset. Ports: clk, rst (async active-low), sb (slave).
module ysyx_25020037_gpr_scoreboard #(
   parameter int NREG  = 16,
   parameter int CNT_W = 2,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   ysyx_25020037_gpr_scoreboard_if.slave sb
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // entry 0 exists only for uniform indexing; it is never written and stays zero
   logic [CNT_W-1:0] cnt [NREG];
   logic             csr_busy;
   logic [2:0]       inflight;
   logic             err_underflow;

   logic [3:0] rs1_idx, rs2_idx, rd_idx, wb_idx;
   logic       hazard;
   logic       fire;
   logic       retire;
   logic       any_cnt;

   assign rs1_idx = sb.rs1[3:0];
   assign rs2_idx = sb.rs2[3:0];
   assign rd_idx  = sb.rd[3:0];
   assign wb_idx  = sb.wb_rd[3:0];

   // Hazard uses only registered state and issue-side inputs; retire inputs never reach issue_ready.
   always_comb begin
      hazard = 1'b0;
      if (sb.rs1_used && rs1_idx != 4'd0 && cnt[rs1_idx] != '0) hazard = 1'b1;
      if (sb.rs2_used && rs2_idx != 4'd0 && cnt[rs2_idx] != '0) hazard = 1'b1;
      if (sb.rd_wen && rd_idx != 4'd0 && cnt[rd_idx] == CNT_MAX) hazard = 1'b1;
      if (sb.csr_op && csr_busy) hazard = 1'b1;
      if (inflight == 3'(DEPTH)) hazard = 1'b1;
   end

   // rst gates readiness so nothing is accepted while reset is held
   assign sb.issue_ready = rst & ~hazard & ~sb.flush;
   assign fire           = sb.idu_valid & sb.issue_ready;
   // a retire during flush is discarded entirely, including its underflow check
   assign retire         = sb.wbu_valid & ~sb.flush;

   always_comb begin
      any_cnt = 1'b0;
      for (int i = 1; i < NREG; i++) begin
         if (cnt[i] != '0) any_cnt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
         csr_busy      <= 1'b0;
         inflight      <= '0;
         err_underflow <= 1'b0;
      end else if (sb.flush) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
         csr_busy <= 1'b0;
         inflight <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            // simultaneous issue and retire on the same register cancel out
            if (fire && sb.rd_wen && rd_idx == 4'(i) &&
                !(retire && sb.wb_wen && wb_idx == 4'(i))) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else if (retire && sb.wb_wen && wb_idx == 4'(i) &&
                         !(fire && sb.rd_wen && rd_idx == 4'(i))) begin
               if (cnt[i] == '0) err_underflow <= 1'b1;
               else              cnt[i] <= cnt[i] - 1'b1;
            end
         end

         // csr_op issue and wb_csr retire are mutually exclusive by the csr_busy hazard
         if (fire && sb.csr_op)         csr_busy <= 1'b1;
         else if (retire && sb.wb_csr)  csr_busy <= 1'b0;

         if (retire && inflight == '0) err_underflow <= 1'b1;
         if (fire && !retire) begin
            inflight <= inflight + 3'd1;
         end else if (retire && !fire && inflight != '0) begin
            inflight <= inflight - 3'd1;
         end
      end
   end

   assign sb.inflight      = inflight;
   assign sb.pend_any      = any_cnt | csr_busy;
   assign sb.err_underflow = err_underflow;

endmodule

// File: tb/tb_ysyx_25020037_gpr_scoreboard.sv
// Directed self-checking bench for ysyx_25020037_gpr_scoreboard.
// Inputs change 1 ns after a rising edge; checks run 1 ns after that, away from the edge.
// Internal counter values are inferred through issue_ready probes and pend_any.
module tb_ysyx_25020037_gpr_scoreboard;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   ysyx_25020037_gpr_scoreboard_if bus ();

   ysyx_25020037_gpr_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .sb  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      bus.idu_valid = 1'b0;
      bus.rs1       = 5'd0;
      bus.rs1_used  = 1'b0;
      bus.rs2       = 5'd0;
      bus.rs2_used  = 1'b0;
      bus.rd        = 5'd0;
      bus.rd_wen    = 1'b0;
      bus.csr_op    = 1'b0;
      bus.wbu_valid = 1'b0;
      bus.wb_rd     = 5'd0;
      bus.wb_wen    = 1'b0;
      bus.wb_csr    = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic set_iss(input logic [4:0] r, input logic w);
      bus.idu_valid = 1'b1;
      bus.rd        = r;
      bus.rd_wen    = w;
   endtask

   task automatic set_ret(input logic [4:0] r, input logic w, input logic c);
      bus.wbu_valid = 1'b1;
      bus.wb_rd     = r;
      bus.wb_wen    = w;
      bus.wb_csr    = c;
   endtask

   // advance one edge, then return inputs to idle
   task automatic tick();
      @(posedge clk);
      #1;
      clr();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      clr();

      // reset held: nothing may issue, status all zero
      #2;
      set_iss(5'd5, 1'b1);
      #1;
      check("rst_ready", bus.issue_ready, 0);
      check("rst_inflight", bus.inflight, 0);
      check("rst_pend", bus.pend_any, 0);
      check("rst_err", bus.err_underflow, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // RAW on x5 with one-cycle retire penalty
      set_iss(5'd5, 1'b1);
      #1 check("t1_issue_rdy", bus.issue_ready, 1);
      tick();
      check("t1_inflight1", bus.inflight, 1);
      check("t1_pend", bus.pend_any, 1);
      bus.idu_valid = 1'b1; bus.rs1 = 5'd5; bus.rs1_used = 1'b1;
      set_ret(5'd5, 1'b1, 1'b0);
      #1 check("t1_raw_block", bus.issue_ready, 0);
      tick();
      check("t1_pend_clear", bus.pend_any, 0);
      bus.idu_valid = 1'b1; bus.rs1 = 5'd5; bus.rs1_used = 1'b1;
      #1 check("t1_raw_release", bus.issue_ready, 1);
      tick();
      check("t1_inflight_dep", bus.inflight, 1);
      set_ret(5'd0, 1'b0, 1'b0);
      tick();
      check("t1_inflight0", bus.inflight, 0);

      // x0 is never tracked
      set_iss(5'd0, 1'b1);
      #1 check("t2_rd0_rdy", bus.issue_ready, 1);
      tick();
      check("t2_inflight1", bus.inflight, 1);
      check("t2_pend0", bus.pend_any, 0);
      bus.idu_valid = 1'b1; bus.rs2 = 5'd0; bus.rs2_used = 1'b1;
      #1 check("t2_rs2_x0_rdy", bus.issue_ready, 1);
      tick();
      check("t2_inflight2", bus.inflight, 2);
      set_ret(5'd0, 1'b1, 1'b0);
      tick();
      set_ret(5'd0, 1'b1, 1'b0);
      tick();
      check("t2_inflight0", bus.inflight, 0);
      check("t2_err0", bus.err_underflow, 0);

      // DEPTH limit
      for (int i = 1; i <= 4; i++) begin
         set_iss(5'(i), 1'b1);
         #1 check("t3_fill_rdy", bus.issue_ready, 1);
         tick();
      end
      check("t3_inflight4", bus.inflight, 4);
      set_iss(5'd9, 1'b1);
      set_ret(5'd1, 1'b1, 1'b0);
      #1 check("t3_full_block", bus.issue_ready, 0);
      tick();
      check("t3_inflight3", bus.inflight, 3);
      set_iss(5'd9, 1'b1);
      #1 check("t3_after_retire_rdy", bus.issue_ready, 1);
      bus.idu_valid = 1'b0;
      bus.flush = 1'b1;
      #1 check("t3_flush_rdy", bus.issue_ready, 0);
      tick();
      check("t3_flush_inflight", bus.inflight, 0);
      check("t3_flush_pend", bus.pend_any, 0);

      // per-register counter saturation and same-register issue+retire
      for (int i = 0; i < 3; i++) begin
         set_iss(5'd7, 1'b1);
         tick();
      end
      check("t4_inflight3", bus.inflight, 3);
      set_iss(5'd7, 1'b1);
      #1 check("t4_sat_block", bus.issue_ready, 0);
      set_ret(5'd7, 1'b1, 1'b0);
      tick();
      set_iss(5'd7, 1'b1);
      set_ret(5'd7, 1'b1, 1'b0);
      #1 check("t4_both_rdy", bus.issue_ready, 1);
      tick();
      check("t4_both_inflight", bus.inflight, 2);
      set_iss(5'd7, 1'b1);
      #1 check("t4_cnt2_rdy", bus.issue_ready, 1);
      tick();
      set_iss(5'd7, 1'b1);
      #1 check("t4_cnt3_block", bus.issue_ready, 0);
      bus.idu_valid = 1'b0;
      bus.flush = 1'b1;
      tick();
      check("t4_flush_pend", bus.pend_any, 0);

      // CSR serialisation
      bus.idu_valid = 1'b1; bus.csr_op = 1'b1;
      #1 check("t5_csr1_rdy", bus.issue_ready, 1);
      tick();
      check("t5_csr_pend", bus.pend_any, 1);
      bus.idu_valid = 1'b1; bus.csr_op = 1'b1;
      set_ret(5'd0, 1'b0, 1'b1);
      #1 check("t5_csr2_block", bus.issue_ready, 0);
      tick();
      check("t5_csr_clear", bus.pend_any, 0);
      bus.idu_valid = 1'b1; bus.csr_op = 1'b1;
      #1 check("t5_csr2_rdy", bus.issue_ready, 1);
      tick();
      set_ret(5'd0, 1'b0, 1'b1);
      tick();
      check("t5_csr_done", bus.inflight, 0);

      // flush with cnt[3]=2, inflight=2, concurrent retire ignored
      set_iss(5'd3, 1'b1);
      tick();
      set_iss(5'd3, 1'b1);
      tick();
      check("t5_pre_flush_inflight", bus.inflight, 2);
      set_iss(5'd4, 1'b1);
      set_ret(5'd3, 1'b1, 1'b0);
      bus.flush = 1'b1;
      tick();
      check("t5_flush_inflight", bus.inflight, 0);
      check("t5_flush_pend", bus.pend_any, 0);
      check("t5_flush_err", bus.err_underflow, 0);
      bus.idu_valid = 1'b1; bus.rs1 = 5'd3; bus.rs1_used = 1'b1;
      #1 check("t5_x3_free", bus.issue_ready, 1);
      bus.idu_valid = 1'b0;

      // underflow, then reset mid-stall
      set_ret(5'd6, 1'b1, 1'b0);
      tick();
      check("t6_err_set", bus.err_underflow, 1);
      check("t6_inflight_hold", bus.inflight, 0);
      set_iss(5'd8, 1'b1);
      tick();
      bus.idu_valid = 1'b1; bus.rs1 = 5'd8; bus.rs1_used = 1'b1;
      #1 check("t6_stall", bus.issue_ready, 0);
      #1 rst = 1'b0;
      #1;
      check("t6_rst_err", bus.err_underflow, 0);
      check("t6_rst_inflight", bus.inflight, 0);
      check("t6_rst_ready", bus.issue_ready, 0);
      check("t6_rst_pend", bus.pend_any, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("t6_post_rst_rdy", bus.issue_ready, 1);
      tick();
      check("t6_post_rst_inflight", bus.inflight, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
